// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx word-port arbiter.
// Latency: none (types/constants only).
// Backpressure: n/a.
package uart_arb_pkg;

   typedef enum logic [0:0] {IDLE, XFER} arb_state_t;

   // Stall threshold used when the release timer is built in.
   localparam int DEFAULT_TIMEOUT = 64;

   // Width of an index able to address n items (never below one bit).
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the winner.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          req,
   input  logic [idx_w(N)-1:0]   ptr,
   output logic [idx_w(N)-1:0]   winner,
   output logic                  any
);

   localparam int IW = idx_w(N);

   logic [IW-1:0] idx;
   logic          found;

   // Scan from ptr+1 around to ptr itself, so the last winner has lowest priority.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx word port; optional stall release via UART_ARB_TIMEOUT_EN.
// Latency: 1 cycle IDLE->XFER to grant, then words pass combinationally; one IDLE bubble between packets.
// Backpressure: m_ready is steered straight to the granted requester's req_ready; no buffering.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int W_OUT          = 24,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*W_OUT-1:0]   req_data,
   input  logic [N_REQ-1:0]         req_last,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     m_valid,
   output logic [W_OUT-1:0]         m_data,
   input  logic                     m_ready,
   output logic [idx_w(N_REQ)-1:0]  grant_id,
   output logic                     busy,
   output logic                     timeout
);

   localparam int IW = idx_w(N_REQ);

   arb_state_t    state, state_nxt;
   logic [IW-1:0] grant_q, grant_nxt;
   logic [IW-1:0] ptr_q, ptr_nxt;
   logic [IW-1:0] pick_idx;
   logic          pick_any;
   logic          stall_release;

   uart_rr_pick #(.N(N_REQ)) u_pick (
      .req    (req_valid),
      .ptr    (ptr_q),
      .winner (pick_idx),
      .any    (pick_any)
   );

`ifdef UART_ARB_TIMEOUT_EN
   localparam int SW = idx_w(TIMEOUT_CYCLES);

   logic [SW-1:0] stall_cnt;

   // A granted requester that has gone quiet long enough loses the grant.
   assign stall_release = (state == XFER) && !req_valid[grant_q]
                          && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

   // Count consecutive XFER cycles with the granted requester idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (state != XFER || req_valid[grant_q] || stall_release) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + SW'(1);
      end
   end
`else
   logic cfg_unused;

   // Without the timer the grant is held until the last word, however long.
   assign stall_release = 1'b0;
   assign cfg_unused    = TIMEOUT_CYCLES[0];
`endif

   assign timeout  = stall_release;
   assign busy     = (state == XFER);
   assign grant_id = grant_q;

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         grant_q <= '0;
         ptr_q   <= IW'(N_REQ - 1);
      end else begin
         state   <= state_nxt;
         grant_q <= grant_nxt;
         ptr_q   <= ptr_nxt;
      end
   end

   // Next-state logic plus the combinational word/ready passthrough.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      ptr_nxt   = ptr_q;
      m_valid   = 1'b0;
      req_ready = '0;
      m_data    = req_data[grant_q*W_OUT +: W_OUT];
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = XFER;
               grant_nxt = pick_idx;
            end
         end
         XFER: begin
            m_valid            = req_valid[grant_q];
            req_ready[grant_q] = m_ready;
            if ((req_valid[grant_q] && m_ready && req_last[grant_q]) || stall_release) begin
               state_nxt = IDLE;
               ptr_nxt   = grant_q;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, W_OUT=24); honours UART_ARB_TIMEOUT_EN.
// Inputs change 1 ns after a rising edge, outputs are sampled 1 ns later.
// Each scenario task compares against hand-derived values and counts results.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [95:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        m_valid;
   logic [23:0] m_data;
   logic        m_ready;
   logic [1:0]  grant_id;
   logic        busy;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.N_REQ(4), .W_OUT(24), .TIMEOUT_CYCLES(64)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .grant_id  (grant_id),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      tick();
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; m_ready = 1'b0;
      #12;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", grant_id); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", timeout); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_packet();
      tick();
      req_valid = 4'b0001; req_data[23:0] = 24'h111111; req_last = 4'b0000; m_ready = 1'b1;
      #1;
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pkt_idle got v=%b b=%b exp 0 0", m_valid, busy); end
      tick();
      checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL pkt_grant got g=%0d b=%b exp 0 1", grant_id, busy); end
      checks++; if (m_data !== 24'h111111 || req_ready !== 4'b0001) begin errors++; $display("FAIL pkt_w1 got %h/%b exp 111111/0001", m_data, req_ready); end
      tick();
      req_data[23:0] = 24'h222222;
      #1;
      checks++; if (m_data !== 24'h222222 || m_valid !== 1'b1) begin errors++; $display("FAIL pkt_w2 got %h v=%b exp 222222 1", m_data, m_valid); end
      tick();
      req_data[23:0] = 24'h333333; req_last = 4'b0001;
      #1;
      checks++; if (m_data !== 24'h333333 || m_valid !== 1'b1) begin errors++; $display("FAIL pkt_w3 got %h v=%b exp 333333 1", m_data, m_valid); end
      tick();
      req_valid = '0; req_last = '0;
      #1;
      checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL pkt_end got b=%b r=%b exp 0 0000", busy, req_ready); end
   endtask

   task automatic test_round_robin();
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      apply_reset();
      for (int i = 0; i < 4; i++) req_data[i*24 +: 24] = 24'hA00000 + 24'(i);
      req_valid = 4'b1111; req_last = 4'b1111; m_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (grant_id !== 2'(exp_seq[k]) || busy !== 1'b1) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", k, grant_id, exp_seq[k]); end
         checks++; if (m_data !== 24'hA00000 + 24'(exp_seq[k]) || req_ready !== (4'b0001 << exp_seq[k])) begin errors++; $display("FAIL rr_word%0d got %h/%b exp %0d", k, m_data, req_ready, exp_seq[k]); end
         tick();
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d got %b exp 0", k, busy); end
      end
      req_valid = '0; req_last = '0;
   endtask

   task automatic test_stall();
      req_valid = 4'b0100; req_data[71:48] = 24'hC0FFEE; req_last = 4'b0100; m_ready = 1'b0;
      tick();
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL stall_grant got %0d exp 2", grant_id); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (m_valid !== 1'b1 || m_data !== 24'hC0FFEE || req_ready !== 4'b0000) begin errors++; $display("FAIL stall_hold%0d got v=%b %h r=%b exp 1 c0ffee 0000", i, m_valid, m_data, req_ready); end
         tick();
      end
      m_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_ready got %b exp 0100", req_ready); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done got %b exp 0", busy); end
      req_valid = '0; req_last = '0;
   endtask

   task automatic test_grant_hold();
      req_valid = 4'b0010; req_data[47:24] = 24'h1A1A1A; req_data[95:72] = 24'h3C3C3C;
      req_last = 4'b0000; m_ready = 1'b1;
      tick();
      checks++; if (grant_id !== 2'd1 || m_data !== 24'h1A1A1A) begin errors++; $display("FAIL hold_grant got %0d %h exp 1 1a1a1a", grant_id, m_data); end
      tick();
      req_valid = 4'b1000; req_last = 4'b1000;
      #1;
`ifdef UART_ARB_TIMEOUT_EN
      for (int i = 0; i < 64; i++) begin
         checks++; if (timeout !== (i == 63) || busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL hold_to%0d got t=%b b=%b v=%b exp t=%b 1 0", i, timeout, busy, m_valid, (i == 63)); end
         if (i < 63) tick();
      end
      tick();
      checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL hold_release got b=%b t=%b exp 0 0", busy, timeout); end
`else
      for (int i = 0; i < 100; i++) begin
         checks++; if (busy !== 1'b1 || grant_id !== 2'd1 || m_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL hold_keep%0d got b=%b g=%0d v=%b t=%b exp 1 1 0 0", i, busy, grant_id, m_valid, timeout); end
         tick();
      end
      req_valid = 4'b1010; req_last = 4'b1010;
      #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 24'h1A1A1A) begin errors++; $display("FAIL hold_resume got v=%b %h exp 1 1a1a1a", m_valid, m_data); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_end got %b exp 0", busy); end
`endif
      tick();
      checks++; if (grant_id !== 2'd3 || m_data !== 24'h3C3C3C) begin errors++; $display("FAIL hold_next got %0d %h exp 3 3c3c3c", grant_id, m_data); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_r3_done got %b exp 0", busy); end
      req_valid = '0; req_last = '0;
   endtask

   task automatic test_reset_mid();
      req_valid = 4'b0001; req_data[23:0] = 24'h0A0A0A; req_last = 4'b0001; m_ready = 1'b1;
      tick();
      tick();
      req_valid = 4'b0100; req_last = 4'b0000; req_data[71:48] = 24'h2B2B2B;
      tick();
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL rmid_grant got %0d exp 2", grant_id); end
      tick();
      req_valid = 4'b0101;
      rstn = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_drop got v=%b b=%b exp 0 0", m_valid, busy); end
      checks++; if (req_ready !== 4'b0000 || grant_id !== 2'd0) begin errors++; $display("FAIL rmid_regs got r=%b g=%0d exp 0000 0", req_ready, grant_id); end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL rmid_first got g=%0d b=%b exp 0 1", grant_id, busy); end
      req_last = 4'b0101;
      tick();
      req_valid = '0; req_last = '0;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      req_valid = 4'b0011; req_data[23:0] = 24'h00A001; req_data[47:24] = 24'h00B001;
      req_last = 4'b0010; m_ready = 1'b1;
      tick();
      checks++; if (grant_id !== 2'd0 || m_data !== 24'h00A001) begin errors++; $display("FAIL b2b_p1w1 got %0d %h exp 0 00a001", grant_id, m_data); end
      tick();
      req_data[23:0] = 24'h00A002; req_last = 4'b0011;
      #1;
      checks++; if (m_data !== 24'h00A002 || busy !== 1'b1) begin errors++; $display("FAIL b2b_p1w2 got %h b=%b exp 00a002 1", m_data, busy); end
      tick();
      req_data[23:0] = 24'h00A003;
      #1;
      checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble got b=%b v=%b exp 0 0", busy, m_valid); end
      tick();
      checks++; if (grant_id !== 2'd1 || m_data !== 24'h00B001) begin errors++; $display("FAIL b2b_r1 got %0d %h exp 1 00b001", grant_id, m_data); end
      tick();
      req_valid = 4'b0001;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle2 got %b exp 0", busy); end
      tick();
      checks++; if (grant_id !== 2'd0 || m_data !== 24'h00A003) begin errors++; $display("FAIL b2b_p2 got %0d %h exp 0 00a003", grant_id, m_data); end
      tick();
      req_valid = '0; req_last = '0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", busy); end
   endtask

   initial begin
      test_reset();
      test_packet();
      test_round_robin();
      test_stall();
      test_grant_hold();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
